// File: rtl/memory_round_ctrl.sv
// memory_round_ctrl: multi-round sequencer for the memorisation game.
//
// Each round requests a fresh random target, shows it for a time that shrinks
// by SHOW_STEP per completed round (floored at SHOW_MIN), then waits for one
// keyboard entry and judges it. Tracks score (round), lives and win/lose.
//
// Ports:
//   clk           system clock, all state on posedge
//   rst           asynchronous active-low reset
//   start         one-cycle pulse, begins a game from IDLE or OVER
//   rand_val      random number, sampled the cycle after new_req
//   new_req       one-cycle pulse asking the random source to advance
//   user_val      keyboard entry, valid with user_ready
//   user_ready    one-cycle entry strobe
//   target        latched target for the display
//   show_phase    high while the target is shown
//   input_phase   high while awaiting an entry
//   verdict_valid high during the verdict hold
//   correct       last judgement, meaningful while verdict_valid
//   round         rounds completed correctly (score)
//   lives         remaining lives
//   game_over     high in OVER
//   win           high in OVER when round == ROUNDS
//
// Optional feature: define INPUT_TIMEOUT_EN to judge an entry as wrong when
// no user_ready arrives within TIMEOUT_CYCLES cycles of INPUT.

module memory_round_ctrl #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SHOW_CYCLES    = 500000000,
    parameter int unsigned SHOW_STEP      = 50000000,
    parameter int unsigned SHOW_MIN       = 100000000,
    parameter int unsigned ROUNDS         = 8,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned VERDICT_CYCLES = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   rand_val,
    output logic                  new_req,
    input  logic [4*DIGITS-1:0]   user_val,
    input  logic                  user_ready,
    output logic [4*DIGITS-1:0]   target,
    output logic                  show_phase,
    output logic                  input_phase,
    output logic                  verdict_valid,
    output logic                  correct,
    output logic [7:0]            round,
    output logic [3:0]            lives,
    output logic                  game_over,
    output logic                  win
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [2:0] {
        StIdle, StLoad, StShow, StInput, StJudge, StVerdict, StOver
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [W-1:0]   target_q, target_d;
    logic           correct_q, correct_d;
    logic [7:0]     round_q, round_d;
    logic [3:0]     lives_q, lives_d;

    // Display time for the current round; the 64-bit product keeps large
    // round*step values from wrapping back into a valid-looking length.
    logic [63:0]    step_total;
    logic [31:0]    show_len;

    always_comb begin
        step_total = 64'(round_q) * 64'(SHOW_STEP);
        show_len   = SHOW_MIN;
        if (step_total < 64'(SHOW_CYCLES) &&
            (SHOW_CYCLES - step_total[31:0]) > SHOW_MIN) begin
            show_len = SHOW_CYCLES - step_total[31:0];
        end
    end

`ifndef INPUT_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        target_d      = target_q;
        correct_d     = correct_q;
        round_d       = round_q;
        lives_d       = lives_q;
        new_req       = 1'b0;
        show_phase    = 1'b0;
        input_phase   = 1'b0;
        verdict_valid = 1'b0;

        case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    new_req = 1'b1;
                    round_d = '0;
                    lives_d = 4'(LIVES);
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                target_d = rand_val;
                cnt_d    = '0;
                state_d  = StShow;
            end
            StShow: begin
                show_phase = 1'b1;
                if (cnt_q == show_len - 32'd1) begin
                    cnt_d   = '0;
                    state_d = StInput;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StInput: begin
                input_phase = 1'b1;
                if (user_ready) begin
                    correct_d = (user_val == target_q);
                    cnt_d     = '0;
                    state_d   = StJudge;
                end
`ifdef INPUT_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                    correct_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StJudge;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            StJudge: begin
                if (correct_q) begin
                    if (round_q < 8'(ROUNDS)) begin
                        round_d = round_q + 8'd1;
                    end
                end else if (lives_q != 4'd0) begin
                    lives_d = lives_q - 4'd1;
                end
                cnt_d   = '0;
                state_d = StVerdict;
            end
            StVerdict: begin
                verdict_valid = 1'b1;
                if (cnt_q == VERDICT_CYCLES - 1) begin
                    cnt_d = '0;
                    if (lives_q == 4'd0 || round_q == 8'(ROUNDS)) begin
                        state_d = StOver;
                    end else begin
                        new_req = 1'b1;
                        state_d = StLoad;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            target_q  <= '0;
            correct_q <= 1'b0;
            round_q   <= '0;
            lives_q   <= 4'(LIVES);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            correct_q <= correct_d;
            round_q   <= round_d;
            lives_q   <= lives_d;
        end
    end

    assign target    = target_q;
    assign correct   = correct_q;
    assign round     = round_q;
    assign lives     = lives_q;
    assign game_over = (state_q == StOver);
    assign win       = (state_q == StOver) && (round_q == 8'(ROUNDS));

endmodule
